// File: rtl/hd_data_rw.sv
// hd_data_rw: test-data pattern source/sink for the faux SATA drive model.
// The writer half streams an incrementing 32-bit word sequence toward the host.
// The reader half checks host words against the same sequence and flags mismatches.
module hd_data_rw #(
  parameter logic [31:0] SEED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_enable,
  output logic [31:0] hd_data_to_host,
  output logic        hd_write_to_host,
  input  logic        rd_enable,
  input  logic        hd_read_from_host,
  input  logic [31:0] hd_data_from_host,
  output logic        rd_error,
  output logic [23:0] rd_count
);

  logic [31:0] wr_val;
  logic [31:0] exp_val;
  logic        rd_mismatch;

  assign rd_mismatch = (hd_data_from_host != exp_val);

  // Writer: emit one word per enabled cycle; any idle cycle restarts the sequence at SEED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_val           <= SEED;
      hd_data_to_host  <= SEED;
      hd_write_to_host <= 1'b0;
    end else if (wr_enable) begin
      hd_write_to_host <= 1'b1;
      hd_data_to_host  <= wr_val;
      wr_val           <= wr_val + 32'd1;
    end else begin
      hd_write_to_host <= 1'b0;
      wr_val           <= SEED;
    end
  end

  // Reader: count strobed words, latch any mismatch, and resync the expected value to the bad word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_val  <= SEED;
      rd_count <= '0;
      rd_error <= 1'b0;
    end else if (!rd_enable) begin
      exp_val  <= SEED;
      rd_count <= '0;
      rd_error <= 1'b0;
    end else if (hd_read_from_host) begin
      rd_count <= rd_count + 24'd1;
      exp_val  <= hd_data_from_host + 32'd1;
      if (rd_mismatch) begin
        rd_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hd_data_rw.sv
// Directed self-checking bench for hd_data_rw.
module tb_hd_data_rw;

  logic        clk;
  logic        rst;
  logic        wr_enable;
  logic        rd_enable;
  logic        tb_strobe;
  logic [31:0] tb_data;
  logic        loop;
  logic [31:0] hd_data_to_host;
  logic        hd_write_to_host;
  logic        rd_strobe;
  logic [31:0] rd_data;
  logic        rd_error;
  logic [23:0] rd_count;

  logic        wr_enable2;
  logic        rd_enable2;
  logic [31:0] data2;
  logic        write2;
  logic        rd_error2;
  logic [23:0] rd_count2;

  int checks;
  int failures;

  assign rd_strobe = loop ? hd_write_to_host : tb_strobe;
  assign rd_data   = loop ? hd_data_to_host  : tb_data;

  hd_data_rw u_dut (
    .clk               (clk),
    .rst               (rst),
    .wr_enable         (wr_enable),
    .hd_data_to_host   (hd_data_to_host),
    .hd_write_to_host  (hd_write_to_host),
    .rd_enable         (rd_enable),
    .hd_read_from_host (rd_strobe),
    .hd_data_from_host (rd_data),
    .rd_error          (rd_error),
    .rd_count          (rd_count)
  );

  hd_data_rw #(.SEED(32'hFFFF_FFFE)) u_wrap (
    .clk               (clk),
    .rst               (rst),
    .wr_enable         (wr_enable2),
    .hd_data_to_host   (data2),
    .hd_write_to_host  (write2),
    .rd_enable         (rd_enable2),
    .hd_read_from_host (write2),
    .hd_data_from_host (data2),
    .rd_error          (rd_error2),
    .rd_count          (rd_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; wr_enable = 1'b1; rd_enable = 1'b1;
    tb_strobe = 1'b1; tb_data = 32'h55; loop = 1'b0;
    wr_enable2 = 1'b0; rd_enable2 = 1'b0;

    // Reset held with enables high
    tick(); tick();
    check("rst_write", {31'd0, hd_write_to_host}, 32'd0);
    check("rst_data", hd_data_to_host, 32'd0);
    check("rst_err", {31'd0, rd_error}, 32'd0);
    check("rst_count", {8'd0, rd_count}, 32'd0);

    // Release with wr_enable high: stream starts at SEED
    tb_strobe = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rel_write", {31'd0, hd_write_to_host}, 32'd1);
      check("rel_data", hd_data_to_host, i);
    end

    // Writer episode: 5 on, 2 off, restart
    wr_enable = 1'b0;
    tick();
    check("ep_idle0", {31'd0, hd_write_to_host}, 32'd0);
    wr_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ep_write", {31'd0, hd_write_to_host}, 32'd1);
      check("ep_data", hd_data_to_host, i);
    end
    wr_enable = 1'b0;
    tick();
    check("ep_stop1", {31'd0, hd_write_to_host}, 32'd0);
    tick();
    check("ep_stop2", {31'd0, hd_write_to_host}, 32'd0);
    wr_enable = 1'b1;
    tick();
    check("ep_restart_w", {31'd0, hd_write_to_host}, 32'd1);
    check("ep_restart_d", hd_data_to_host, 32'd0);
    tick();
    check("ep_restart_d1", hd_data_to_host, 32'd1);
    wr_enable = 1'b0;

    // Mismatch: 0,1,7,8 (strobe in first rd_enable cycle compared to SEED)
    rd_enable = 1'b0;
    tick();
    rd_enable = 1'b1; tb_strobe = 1'b1;
    tb_data = 32'd0; tick();
    check("mm_cnt1", {8'd0, rd_count}, 32'd1);
    check("mm_err1", {31'd0, rd_error}, 32'd0);
    tb_data = 32'd1; tick();
    check("mm_cnt2", {8'd0, rd_count}, 32'd2);
    check("mm_err2", {31'd0, rd_error}, 32'd0);
    tb_data = 32'd7; tick();
    check("mm_cnt3", {8'd0, rd_count}, 32'd3);
    check("mm_err3", {31'd0, rd_error}, 32'd1);
    tb_data = 32'd8; tick();
    check("mm_cnt4", {8'd0, rd_count}, 32'd4);
    check("mm_err4", {31'd0, rd_error}, 32'd1);
    tb_strobe = 1'b0; tick();
    check("mm_sticky", {31'd0, rd_error}, 32'd1);
    check("mm_hold", {8'd0, rd_count}, 32'd4);
    rd_enable = 1'b0; tick();
    check("mm_clr_err", {31'd0, rd_error}, 32'd0);
    check("mm_clr_cnt", {8'd0, rd_count}, 32'd0);

    // Strobe gating: strobes while rd_enable low are ignored
    tb_strobe = 1'b1; tb_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_cnt", {8'd0, rd_count}, 32'd0);
      check("gate_err", {31'd0, rd_error}, 32'd0);
    end
    tb_strobe = 1'b0;

    // Loopback 1000 words (reader lags writer by one cycle)
    loop = 1'b1; wr_enable = 1'b1; rd_enable = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    check("lb_cnt_lag", {8'd0, rd_count}, 32'd999);
    wr_enable = 1'b0;
    tick();
    check("lb_cnt", {8'd0, rd_count}, 32'd1000);
    check("lb_err", {31'd0, rd_error}, 32'd0);
    tick();
    check("lb_after_stop", {8'd0, rd_count}, 32'd1000);
    check("lb_write_off", {31'd0, hd_write_to_host}, 32'd0);

    // Async reset mid-stream, then restart with wr_enable still high
    wr_enable = 1'b1;
    tick(); tick(); tick();
    check("ar_pre_data", hd_data_to_host, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("ar_write", {31'd0, hd_write_to_host}, 32'd0);
    check("ar_data", hd_data_to_host, 32'd0);
    check("ar_cnt", {8'd0, rd_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ar_restart_w", {31'd0, hd_write_to_host}, 32'd1);
    check("ar_restart_d", hd_data_to_host, 32'd0);
    wr_enable = 1'b0; rd_enable = 1'b0; loop = 1'b0;

    // Wrap: SEED=FFFF_FFFE loopback
    wr_enable2 = 1'b1; rd_enable2 = 1'b1;
    tick(); check("wr_d0", data2, 32'hFFFF_FFFE);
    tick(); check("wr_d1", data2, 32'hFFFF_FFFF);
    tick(); check("wr_d2", data2, 32'h0000_0000);
    tick(); check("wr_d3", data2, 32'h0000_0001);
    wr_enable2 = 1'b0;
    tick();
    check("wr_cnt", {8'd0, rd_count2}, 32'd4);
    check("wr_err", {31'd0, rd_error2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
